// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end.
//   fetch_state_t    : encoding of the instruction-fetch state machine
//   RESET_PC_DEFAULT : default program counter after reset
//   NOP              : value held in the IF/ID instruction field after reset
package mips_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,  // request presented to instruction memory
        S_WAIT  = 2'd1,  // request accepted, waiting for read data
        S_HOLD  = 2'd2,  // instruction presented to IF/ID, waiting for transfer
        S_DRAIN = 2'd3   // waiting to discard a response made stale by a redirect
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage. Owns the PC, issues one outstanding read at a time
// to instruction memory and presents {out_instr, out_pc} to the IF/ID register.
//   clock, reset_n          : clock, synchronous active-low reset
//   redirect, redirect_pc   : one-cycle re-steer from branch/jump resolution
//   imem_req/addr/gnt       : read request channel (accepted on req & gnt)
//   imem_rvalid/rdata       : read response channel
//   out_valid/instr/pc      : fetched instruction and its address
//   out_ready               : IF/ID accepts (transfer = out_valid & out_ready)
//   fetch_count             : number of completed transfers, wraps at 2^32
module if_fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              out_ready,
    output logic [31:0]       fetch_count
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] redirect_target;
    logic              transfer;
    logic              capture;

    // Word-align the redirect target by masking the low two bits.
    assign redirect_target = redirect_pc & ~ADDR_W'(3);
    assign imem_addr       = pc;
    assign transfer        = out_valid & out_ready;
    assign capture         = (state == S_WAIT) & imem_rvalid & ~redirect;

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; redirect takes priority over every other event.
    always_comb begin
        state_next = state;
        unique case (state)
            S_REQ: begin
                if (imem_gnt) begin
                    // A grant in the redirect cycle accepts the old address,
                    // whose response must then be drained.
                    state_next = redirect ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    state_next = imem_rvalid ? S_REQ : S_DRAIN;
                end else if (imem_rvalid) begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect || transfer) begin
                    state_next = S_REQ;
                end
            end
            S_DRAIN: begin
                // A redirect here only updates pc; the stale response still
                // ends the drain, otherwise fetch would wait forever.
                if (imem_rvalid) begin
                    state_next = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase
    end

    // Output decode; reset overrides the state decode.
    always_comb begin
        imem_req  = reset_n & (state == S_REQ);
        out_valid = reset_n & (state == S_HOLD) & ~redirect;
    end

    // Datapath: PC, IF/ID payload, transfer counter
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            out_instr   <= DATA_W'(NOP);
            out_pc      <= '0;
            fetch_count <= '0;
        end else begin
            if (redirect) begin
                pc <= redirect_target;
            end else if (transfer) begin
                pc <= pc + ADDR_W'(4);
            end
            if (capture) begin
                out_instr <= imem_rdata;
                out_pc    <= pc;
            end
            if (transfer) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed scenarios followed by randomized
// stimulus, with a transaction-level reference model and a memory responder.
module tb_if_fetch_unit;

    logic        clock;
    logic        reset_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;
    logic [31:0] fetch_count;

    int unsigned total = 0;
    int unsigned bad   = 0;

    if_fetch_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_ready   (out_ready),
        .fetch_count (fetch_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: fetch address, one outstanding request (possibly
    // stale), and a one-entry output buffer.
    logic [31:0] m_pc;
    logic        m_out;
    logic        m_stale;
    logic [31:0] m_req_addr;
    logic        m_buf;
    logic [31:0] m_instr;
    logic [31:0] m_opc;
    logic [31:0] m_cnt;

    // Memory responder
    logic        mem_pending;
    int unsigned mem_cnt;
    logic [31:0] mem_addr;
    int unsigned lat_cfg;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic model_reset();
        m_pc    = 32'h0;
        m_out   = 1'b0;
        m_stale = 1'b0;
        m_buf   = 1'b0;
        m_instr = 32'h0;
        m_opc   = 32'h0;
        m_cnt   = 32'h0;
        mem_pending = 1'b0;
    endtask

    task automatic step(input logic rst, input logic rd, input logic [31:0] rpc,
                        input logic g, input logic rdy);
        logic exp_req, exp_valid, accept, xfer, resp;
        @(negedge clock);
        reset_n     = rst;
        redirect    = rd;
        redirect_pc = rpc;
        imem_gnt    = g;
        out_ready   = rdy;
        if (mem_pending && mem_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_f(mem_addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        exp_req   = rst && !m_out && !m_buf;
        exp_valid = rst && m_buf && !rd;
        chk("imem_req",    {31'b0, imem_req},  {31'b0, exp_req});
        chk("imem_addr",   imem_addr,          m_pc);
        chk("out_valid",   {31'b0, out_valid}, {31'b0, exp_valid});
        chk("out_instr",   out_instr,          m_instr);
        chk("out_pc",      out_pc,             m_opc);
        chk("fetch_count", fetch_count,        m_cnt);
        @(posedge clock);
        if (!rst) begin
            model_reset();
        end else begin
            accept = exp_req && g;
            xfer   = exp_valid && rdy;
            resp   = imem_rvalid && m_out;
            // memory side
            if (imem_rvalid) mem_pending = 1'b0;
            else if (mem_pending) mem_cnt--;
            if (accept) begin
                mem_pending = 1'b1;
                mem_cnt     = lat_cfg - 1;
                mem_addr    = m_pc;
            end
            // fetch side
            if (resp) begin
                m_out = 1'b0;
                if (!m_stale && !rd) begin
                    m_buf   = 1'b1;
                    m_instr = imem_rdata;
                    m_opc   = m_req_addr;
                end
                m_stale = 1'b0;
            end
            if (accept) begin
                m_out      = 1'b1;
                m_stale    = 1'b0;
                m_req_addr = m_pc;
            end
            if (rd) begin
                m_pc  = {rpc[31:2], 2'b00};
                m_buf = 1'b0;
                if (m_out) m_stale = 1'b1;
            end else if (xfer) begin
                m_buf = 1'b0;
                m_pc  = m_pc + 32'd4;
                m_cnt = m_cnt + 32'd1;
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; out_ready = 1'b0;
        lat_cfg = 1;
        @(posedge clock);
        model_reset();

        // Reset values
        repeat (2) step(0, 0, 0, 1, 1);

        // Back-to-back fetch: 3 cycles per instruction
        lat_cfg = 1;
        repeat (9) step(1, 0, 0, 1, 1);
        #1 chk("cnt_after_9", fetch_count, 32'd3);

        // Downstream stall for 5 cycles in HOLD
        repeat (2) step(1, 0, 0, 1, 1);
        repeat (5) step(1, 0, 0, 1, 0);
        #1 chk("stall_pc", out_pc, 32'hC);
        step(1, 0, 0, 1, 1);
        #1 chk("cnt_after_stall", fetch_count, 32'd4);

        // Redirect while waiting; stale data arrives 3 cycles later
        lat_cfg = 4;
        step(1, 0, 0, 1, 1);
        step(1, 1, 32'h103, 0, 1);
        repeat (3) step(1, 0, 0, 0, 1);
        #1 chk("addr_after_drain", imem_addr, 32'h100);
        lat_cfg = 1;
        repeat (2) step(1, 0, 0, 1, 1);
        #1 chk("pc_after_drain", out_pc, 32'h100);
        step(1, 0, 0, 1, 1);

        // Redirect in HOLD with out_ready=1 in the same cycle
        repeat (2) step(1, 0, 0, 1, 1);
        step(1, 1, 32'h200, 1, 1);
        #1 chk("addr_hold_redir", imem_addr, 32'h200);
        chk("cnt_hold_redir", fetch_count, 32'd5);

        // Grant withheld, then redirect before grant
        repeat (4) step(1, 0, 0, 0, 1);
        step(1, 1, 32'h300, 0, 1);
        #1 chk("addr_req_redir", imem_addr, 32'h300);
        repeat (2) step(1, 0, 0, 1, 1);
        #1 chk("pc_req_redir", out_pc, 32'h300);
        step(1, 0, 0, 1, 1);

        // Reset while waiting for data
        lat_cfg = 3;
        repeat (2) step(1, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        #1 chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_count", fetch_count, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);

        // PC wrap from the top of the address space
        lat_cfg = 1;
        step(1, 1, 32'hFFFF_FFFC, 0, 1);
        repeat (3) step(1, 0, 0, 1, 1);
        #1 chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_pc", out_pc, 32'hFFFF_FFFC);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            lat_cfg = $urandom_range(1, 3);
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 7) == 0),
                 $urandom,
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) < 7));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
